// File: rtl/decode_stage_pkg.sv
// Shared decode constants: opcodes, funct codes, PC-select encodings and
// the register index width used by the decode stage and its register file.
package decode_stage_pkg;

    // Register index width (32 architectural registers)
    localparam int REG_IDX_W = 5;

    // Primary opcodes recognised in ID
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // R-type funct codes for register-indirect jumps
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    // PC source selection driven to FETCH
    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'd0,  // PC + 1
        PC_SRC_REG    = 2'd1,  // register target (JR/JALR)
        PC_SRC_TARGET = 2'd2   // branch or jump target
    } pc_src_e;

    // True for the two register-indirect jump encodings
    function automatic logic is_reg_jump(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 32-entry register file: two read ports with write-through from the
// writeback port, one write port, one debug read port; r0 reads as zero.
module register_file
    import decode_stage_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = REG_IDX_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               write_en,
    input  logic [NB_REG-1:0]  write_addr,
    input  logic [NB_DATA-1:0] write_data,
    input  logic [NB_REG-1:0]  rs_addr,
    input  logic [NB_REG-1:0]  rt_addr,
    input  logic [NB_REG-1:0]  dbg_addr,
    output logic [NB_DATA-1:0] rs_data,
    output logic [NB_DATA-1:0] rt_data,
    output logic [NB_DATA-1:0] dbg_data
);

    localparam int DEPTH = 1 << NB_REG;

    logic [NB_DATA-1:0] regs [DEPTH];
    logic               do_write;

    // Writes are gated by the pipeline enable and never touch r0
    assign do_write = enable && write_en && (write_addr != '0);

    // Register array update; reset clears every entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (do_write) begin
            regs[write_addr] <= write_data;
        end
    end

    // Read port rs with same-cycle write-through
    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (do_write && (write_addr == rs_addr)) begin
            rs_data = write_data;
        end
    end

    // Read port rt with same-cycle write-through
    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (do_write && (write_addr == rt_addr)) begin
            rt_data = write_data;
        end
    end

    // Debug port shows committed register contents only
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/decode_stage.sv
// ID stage: IF/ID register, register file, branch/jump resolution with
// MEM-stage forwarding for compare operands, hazard stalls and halt latch.
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int NB_INST = 32,
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = `ADDRWIDTH,
    parameter int NB_REG  = REG_IDX_W
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [NB_INST-1:0] i_instruction,
    input  logic [NB_ADDR-1:0] i_pc_plus1,
    input  logic               i_wb_reg_write,
    input  logic [NB_REG-1:0]  i_wb_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic               i_ex_reg_write,
    input  logic               i_ex_mem_read,
    input  logic [NB_REG-1:0]  i_ex_rd,
    input  logic               i_mem_reg_write,
    input  logic               i_mem_mem_read,
    input  logic [NB_REG-1:0]  i_mem_rd,
    input  logic [NB_DATA-1:0] i_mem_alu_result,
    input  logic [NB_REG-1:0]  i_dbg_reg_addr,
    output logic               o_pc_write,
    output logic [1:0]         o_pc_src,
    output logic               o_jump_or_branch,
    output logic [NB_ADDR-1:0] o_addr_branch,
    output logic [NB_ADDR-1:0] o_addr_jump,
    output logic [NB_ADDR-1:0] o_addr_register,
    output logic               o_bubble,
    output logic [NB_INST-1:0] o_instruction,
    output logic [NB_ADDR-1:0] o_pc_plus1,
    output logic [NB_DATA-1:0] o_rs_data,
    output logic [NB_DATA-1:0] o_rt_data,
    output logic [NB_DATA-1:0] o_imm_ext,
    output logic               o_halt,
    output logic [NB_DATA-1:0] o_dbg_reg_data
);

    // IF/ID contents and sticky halt
    logic [NB_INST-1:0] instr;
    logic [NB_ADDR-1:0] pc_plus1;
    logic               halted;

    // Instruction fields
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [NB_REG-1:0]  rs;
    logic [NB_REG-1:0]  rt;
    logic [15:0]        imm;

    // Decode flags
    logic               is_branch;
    logic               is_jump;
    logic               is_jr;
    logic               is_halt;

    // Operands
    logic [NB_DATA-1:0] rs_rf;
    logic [NB_DATA-1:0] rt_rf;
    logic [NB_DATA-1:0] rs_fwd;
    logic [NB_DATA-1:0] rt_fwd;
    logic               branch_taken;

    // Hazard and control
    logic               load_use;
    logic               ex_ctrl_hazard;
    logic               mem_ctrl_hazard;
    logic               stall;
    logic               halt_now;
    logic               redirect;
    pc_src_e            pc_src;
    logic               jump_or_branch;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign imm    = instr[15:0];
    assign funct  = instr[5:0];

    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
    assign is_jr     = is_reg_jump(opcode, funct);
    assign is_halt   = (opcode == OP_HALT);

    register_file #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG)
    ) u_register_file (
        .clk        (i_clk),
        .reset      (i_reset),
        .enable     (i_enable),
        .write_en   (i_wb_reg_write),
        .write_addr (i_wb_addr),
        .write_data (i_wb_data),
        .rs_addr    (rs),
        .rt_addr    (rt),
        .dbg_addr   (i_dbg_reg_addr),
        .rs_data    (rs_rf),
        .rt_data    (rt_rf),
        .dbg_data   (o_dbg_reg_data)
    );

    // Forward EX/MEM ALU results into the compare/JR operands; loads in MEM
    // are not forwardable here and are handled as a stall instead
    always_comb begin
        rs_fwd = rs_rf;
        rt_fwd = rt_rf;
        if (i_mem_reg_write && !i_mem_mem_read && (i_mem_rd == rs) && (rs != '0)) begin
            rs_fwd = i_mem_alu_result;
        end
        if (i_mem_reg_write && !i_mem_mem_read && (i_mem_rd == rt) && (rt != '0)) begin
            rt_fwd = i_mem_alu_result;
        end
    end

    assign branch_taken = (opcode == OP_BEQ) ? (rs_fwd == rt_fwd) :
                          (opcode == OP_BNE) ? (rs_fwd != rt_fwd) : 1'b0;

    // Target addresses, all arithmetic modulo 2^NB_ADDR
    assign o_addr_branch   = pc_plus1 + NB_ADDR'($signed(imm));
    assign o_addr_register = NB_ADDR'(rs_fwd);

    generate
        if (NB_ADDR > 26) begin : g_jump_wide
            assign o_addr_jump = {pc_plus1[NB_ADDR-1:26], instr[25:0]};
        end else begin : g_jump_narrow
            assign o_addr_jump = instr[NB_ADDR-1:0];
        end
    endgenerate

    // Hazard detection: load-use on either source, plus control-flow
    // operands still being produced in EX or loaded in MEM
    always_comb begin
        load_use        = i_ex_mem_read && (i_ex_rd != '0) &&
                          ((i_ex_rd == rs) || (i_ex_rd == rt));
        ex_ctrl_hazard  = i_ex_reg_write && (i_ex_rd != '0) &&
                          (((is_branch || is_jr) && (i_ex_rd == rs)) ||
                           (is_branch && (i_ex_rd == rt)));
        mem_ctrl_hazard = i_mem_mem_read && (i_mem_rd != '0) &&
                          (((is_branch || is_jr) && (i_mem_rd == rs)) ||
                           (is_branch && (i_mem_rd == rt)));
        stall           = load_use || ex_ctrl_hazard || mem_ctrl_hazard;
    end

    // PC select: a stall forces sequential so FETCH never redirects early
    always_comb begin
        pc_src         = PC_SRC_SEQ;
        jump_or_branch = 1'b0;
        if (!stall) begin
            if (branch_taken) begin
                pc_src         = PC_SRC_TARGET;
                jump_or_branch = 1'b0;
            end else if (is_jump) begin
                pc_src         = PC_SRC_TARGET;
                jump_or_branch = 1'b1;
            end else if (is_jr) begin
                pc_src         = PC_SRC_REG;
            end
        end
    end

    assign halt_now = halted || is_halt;
    assign redirect = (pc_src != PC_SRC_SEQ);

    // IF/ID register and halt latch; stall beats flush, flush beats load,
    // and a halted pipeline keeps the HALT word in ID
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            instr    <= '0;
            pc_plus1 <= '0;
            halted   <= 1'b0;
        end else if (i_enable) begin
            if (is_halt) begin
                halted <= 1'b1;
            end
            if (!stall && !halt_now) begin
                if (redirect) begin
                    instr    <= '0;
                    pc_plus1 <= '0;
                end else begin
                    instr    <= i_instruction;
                    pc_plus1 <= i_pc_plus1;
                end
            end
        end
    end

    assign o_pc_write       = i_enable && !stall && !halt_now;
    assign o_pc_src         = pc_src;
    assign o_jump_or_branch = jump_or_branch;
    assign o_bubble         = stall;
    assign o_instruction    = instr;
    assign o_pc_plus1       = pc_plus1;
    assign o_rs_data        = rs_rf;
    assign o_rt_data        = rt_rf;
    assign o_imm_ext        = NB_DATA'($signed(imm));
    assign o_halt           = halt_now;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, branches, jumps, hazards,
// forwarding, enable freeze and halt.
`timescale 1ns/1ps
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_rw;
    logic        ex_mr;
    logic [4:0]  ex_rd;
    logic        mem_rw;
    logic        mem_mr;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu;
    logic [4:0]  dbg_addr;

    logic        pc_write;
    logic [1:0]  pc_src;
    logic        jb;
    logic [31:0] addr_branch;
    logic [31:0] addr_jump;
    logic [31:0] addr_register;
    logic        bubble;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic        halt;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] BEQ_R1_R2_P7  = {6'd4, 5'd1, 5'd2, 16'd7};
    localparam logic [31:0] J_8           = {6'd2, 26'd8};
    localparam logic [31:0] BNE_R1_R2_M1  = {6'd5, 5'd1, 5'd2, 16'hFFFF};
    localparam logic [31:0] BNE_R1_R0_P3  = {6'd5, 5'd1, 5'd0, 16'd3};
    localparam logic [31:0] ADDU_R4_R5_R1 = {6'd0, 5'd5, 5'd1, 5'd4, 5'd0, 6'h21};
    localparam logic [31:0] JR_R3         = {6'd0, 5'd3, 15'd0, 6'h08};
    localparam logic [31:0] HALT_W        = {6'h3F, 26'd0};
    localparam logic [31:0] FILLER        = {6'd0, 5'd6, 5'd7, 5'd8, 5'd0, 6'h21};

    decode_stage #(
        .NB_INST (32),
        .NB_DATA (32),
        .NB_ADDR (32),
        .NB_REG  (5)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_enable         (enable),
        .i_instruction    (instruction),
        .i_pc_plus1       (pc_in),
        .i_wb_reg_write   (wb_we),
        .i_wb_addr        (wb_addr),
        .i_wb_data        (wb_data),
        .i_ex_reg_write   (ex_rw),
        .i_ex_mem_read    (ex_mr),
        .i_ex_rd          (ex_rd),
        .i_mem_reg_write  (mem_rw),
        .i_mem_mem_read   (mem_mr),
        .i_mem_rd         (mem_rd),
        .i_mem_alu_result (mem_alu),
        .i_dbg_reg_addr   (dbg_addr),
        .o_pc_write       (pc_write),
        .o_pc_src         (pc_src),
        .o_jump_or_branch (jb),
        .o_addr_branch    (addr_branch),
        .o_addr_jump      (addr_jump),
        .o_addr_register  (addr_register),
        .o_bubble         (bubble),
        .o_instruction    (instr_out),
        .o_pc_plus1       (pc_out),
        .o_rs_data        (rs_data),
        .o_rt_data        (rt_data),
        .o_imm_ext        (imm_ext),
        .o_halt           (halt),
        .o_dbg_reg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then changed away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_side();
        wb_we  = 1'b0; wb_addr = '0; wb_data = '0;
        ex_rw  = 1'b0; ex_mr   = 1'b0; ex_rd  = '0;
        mem_rw = 1'b0; mem_mr  = 1'b0; mem_rd = '0; mem_alu = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; instruction = '0; pc_in = '0; dbg_addr = '0;
        clear_side();
        tick();
        reset = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'd99; dbg_addr = 5'd3;
        tick();
        clear_side();
        #1;
        checks++; if (dbg_data !== 32'd99) begin errors++; $display("FAIL pre_reset_r3: got %0d expected 99", dbg_data); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL reset_r3: got %0d expected 0", dbg_data); end
        checks++; if (instr_out !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr_out); end
        checks++; if (pc_src !== 2'd0) begin errors++; $display("FAIL reset_pc_src: got %0d expected 0", pc_src); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write: got %0b expected 1", pc_write); end
        checks++; if (bubble !== 1'b0 || halt !== 1'b0 || jb !== 1'b0) begin errors++; $display("FAIL reset_flags: got bubble=%0b halt=%0b jb=%0b expected 0", bubble, halt, jb); end
    endtask

    task automatic test_branch();
        instruction = BEQ_R1_R2_P7; pc_in = 32'd5;
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd10;
        tick();
        instruction = FILLER; pc_in = 32'd6;
        wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'd10;
        #1;
        checks++; if (rt_data !== 32'd10) begin errors++; $display("FAIL beq_write_through: got %0d expected 10", rt_data); end
        checks++; if (pc_src !== 2'd2) begin errors++; $display("FAIL beq_src: got %0d expected 2", pc_src); end
        checks++; if (jb !== 1'b0) begin errors++; $display("FAIL beq_jb: got %0b expected 0", jb); end
        checks++; if (addr_branch !== 32'd12) begin errors++; $display("FAIL beq_target: got %0d expected 12", addr_branch); end
        tick();
        clear_side();
        #1;
        checks++; if (instr_out !== 32'd0 || pc_out !== 32'd0) begin errors++; $display("FAIL beq_flush: got instr=%h pc=%0d expected 0/0", instr_out, pc_out); end
    endtask

    task automatic test_jump();
        instruction = J_8; pc_in = 32'd7;
        tick();
        instruction = FILLER;
        #1;
        checks++; if (pc_src !== 2'd2 || jb !== 1'b1) begin errors++; $display("FAIL j_src: got src=%0d jb=%0b expected 2/1", pc_src, jb); end
        checks++; if (addr_jump !== 32'd8) begin errors++; $display("FAIL j_target: got %0d expected 8", addr_jump); end
        tick();
        instruction = BNE_R1_R2_M1; pc_in = 32'd20;
        tick();
        instruction = FILLER;
        #1;
        checks++; if (pc_src !== 2'd0) begin errors++; $display("FAIL bne_equal_src: got %0d expected 0", pc_src); end
        checks++; if (addr_branch !== 32'd19) begin errors++; $display("FAIL bne_neg_target: got %0d expected 19", addr_branch); end
        checks++; if (imm_ext !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bne_imm_ext: got %h expected ffffffff", imm_ext); end
        instruction = BNE_R1_R0_P3; pc_in = 32'd40;
        tick();
        instruction = FILLER;
        #1;
        checks++; if (pc_src !== 2'd2 || addr_branch !== 32'd43) begin errors++; $display("FAIL bne_taken: got src=%0d target=%0d expected 2/43", pc_src, addr_branch); end
        tick();
    endtask

    task automatic test_load_use();
        instruction = ADDU_R4_R5_R1; pc_in = 32'd50;
        tick();
        instruction = FILLER; pc_in = 32'd51;
        ex_mr = 1'b1; ex_rw = 1'b1; ex_rd = 5'd5;
        #1;
        checks++; if (pc_write !== 1'b0 || bubble !== 1'b1 || pc_src !== 2'd0) begin errors++; $display("FAIL lu_stall: got pcw=%0b bubble=%0b src=%0d expected 0/1/0", pc_write, bubble, pc_src); end
        tick();
        clear_side();
        #1;
        checks++; if (instr_out !== ADDU_R4_R5_R1 || pc_out !== 32'd50) begin errors++; $display("FAIL lu_hold: got instr=%h pc=%0d expected %h/50", instr_out, pc_out, ADDU_R4_R5_R1); end
        checks++; if (pc_write !== 1'b1 || bubble !== 1'b0) begin errors++; $display("FAIL lu_release: got pcw=%0b bubble=%0b expected 1/0", pc_write, bubble); end
        tick();
        #1;
        checks++; if (instr_out !== FILLER || pc_out !== 32'd51) begin errors++; $display("FAIL lu_advance: got instr=%h pc=%0d expected %h/51", instr_out, pc_out, FILLER); end
    endtask

    task automatic test_jr();
        instruction = JR_R3; pc_in = 32'd60;
        tick();
        instruction = FILLER;
        mem_rw = 1'b1; mem_rd = 5'd3; mem_alu = 32'd30;
        #1;
        checks++; if (pc_src !== 2'd1 || addr_register !== 32'd30) begin errors++; $display("FAIL jr_mem_fwd: got src=%0d target=%0d expected 1/30", pc_src, addr_register); end
        checks++; if (pc_write !== 1'b1 || bubble !== 1'b0) begin errors++; $display("FAIL jr_no_stall: got pcw=%0b bubble=%0b expected 1/0", pc_write, bubble); end
        tick();
        clear_side();
        instruction = JR_R3;
        tick();
        instruction = FILLER;
        ex_rw = 1'b1; ex_rd = 5'd3;
        #1;
        checks++; if (pc_write !== 1'b0 || bubble !== 1'b1 || pc_src !== 2'd0) begin errors++; $display("FAIL jr_ex_stall: got pcw=%0b bubble=%0b src=%0d expected 0/1/0", pc_write, bubble, pc_src); end
        tick();
        clear_side();
        mem_rw = 1'b1; mem_rd = 5'd3; mem_alu = 32'd44;
        #1;
        checks++; if (instr_out !== JR_R3) begin errors++; $display("FAIL jr_held: got %h expected %h", instr_out, JR_R3); end
        checks++; if (pc_src !== 2'd1 || addr_register !== 32'd44 || pc_write !== 1'b1) begin errors++; $display("FAIL jr_after_stall: got src=%0d target=%0d pcw=%0b expected 1/44/1", pc_src, addr_register, pc_write); end
        clear_side();
        mem_mr = 1'b1; mem_rw = 1'b1; mem_rd = 5'd3;
        #1;
        checks++; if (bubble !== 1'b1 || pc_src !== 2'd0) begin errors++; $display("FAIL jr_mem_load_stall: got bubble=%0b src=%0d expected 1/0", bubble, pc_src); end
        clear_side();
        tick();
        instruction = FILLER;
        tick();
    endtask

    task automatic test_enable();
        instruction = ADDU_R4_R5_R1; pc_in = 32'd9;
        tick();
        enable = 1'b0;
        instruction = J_8; pc_in = 32'd77;
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'd77; dbg_addr = 5'd7;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL en_pc_write: got %0b expected 0", pc_write); end
        tick();
        tick();
        #1;
        checks++; if (instr_out !== ADDU_R4_R5_R1 || pc_out !== 32'd9) begin errors++; $display("FAIL en_ifid_frozen: got instr=%h pc=%0d expected %h/9", instr_out, pc_out, ADDU_R4_R5_R1); end
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL en_reg_frozen: got %0d expected 0", dbg_data); end
        enable = 1'b1;
        clear_side();
        instruction = FILLER;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        instruction = ADDU_R4_R5_R1; pc_in = 32'd90;
        tick();
        ex_mr = 1'b1; ex_rd = 5'd5; instruction = FILLER;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rms_stall: got %0b expected 0", pc_write); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (instr_out !== 32'd0 || pc_write !== 1'b1 || bubble !== 1'b0) begin errors++; $display("FAIL rms_clear: got instr=%h pcw=%0b bubble=%0b expected 0/1/0", instr_out, pc_write, bubble); end
        clear_side();
    endtask

    task automatic test_halt();
        instruction = HALT_W; pc_in = 32'd100;
        tick();
        instruction = FILLER;
        #1;
        checks++; if (halt !== 1'b1 || pc_write !== 1'b0) begin errors++; $display("FAIL halt_set: got halt=%0b pcw=%0b expected 1/0", halt, pc_write); end
        tick();
        tick();
        #1;
        checks++; if (halt !== 1'b1 || pc_write !== 1'b0) begin errors++; $display("FAIL halt_sticky: got halt=%0b pcw=%0b expected 1/0", halt, pc_write); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        instruction = '0;
        #1;
        checks++; if (halt !== 1'b0 || pc_write !== 1'b1 || instr_out !== 32'd0) begin errors++; $display("FAIL halt_reset: got halt=%0b pcw=%0b instr=%h expected 0/1/0", halt, pc_write, instr_out); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_load_use();
        test_jr();
        test_enable();
        test_reset_mid_stall();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
ID stage of the MIPS pipeline, directly downstream of FETCH. It holds the IF/ID register and the 32x32 register file. It resolves branches, jumps and JR/JALR in ID, and drives FETCH's PC-select inputs. It detects load-use and branch-operand hazards, then stalls FETCH and inserts bubbles toward ID/EX.

Parameters:
NB_INST, 32, instruction width
NB_DATA, 32, register/data width
NB_ADDR, `ADDRWIDTH, PC width (word addresses; PC+1 = next instruction)
NB_REG, 5, register index width

Ports:
i_clk  in  1  clock, all state updated on posedge
i_reset  in  1  synchronous, active-high
i_enable  in  1  pipeline enable from debug unit; 0 freezes all state
i_instruction  in  NB_INST  from FETCH o_instruction
i_pc_plus1  in  NB_ADDR  from FETCH o_PCAddr
i_wb_reg_write / i_wb_addr / i_wb_data  in  1/NB_REG/NB_DATA  writeback port
i_ex_reg_write / i_ex_mem_read / i_ex_rd  in  1/1/NB_REG  ID/EX destination info
i_mem_reg_write / i_mem_mem_read / i_mem_rd / i_mem_alu_result  in  1/1/NB_REG/NB_DATA  EX/MEM info + forward value
i_dbg_reg_addr  in  NB_REG  debug read address
o_pc_write  out  1  to FETCH enable; 0 = stall PC
o_pc_src  out  2  0=PC+1, 1=register, 2=branch/jump
o_jump_or_branch  out  1  valid when o_pc_src=2: 0 branch, 1 jump
o_addr_branch / o_addr_jump / o_addr_register  out  NB_ADDR  targets to FETCH
o_bubble  out  1  ID/EX must load NOP this cycle
o_instruction / o_pc_plus1  out  NB_INST/NB_ADDR  IF/ID contents
o_rs_data / o_rt_data / o_imm_ext  out  NB_DATA  operands, sign-extended imm
o_halt  out  1  sticky, HALT (opcode 6'b111111) decoded
o_dbg_reg_data  out  NB_DATA  regfile[i_dbg_reg_addr]

Behaviour:
- Reset: IF/ID = 0 (NOP), pc_plus1 = 0, all registers = 0, o_halt = 0. With IF/ID = NOP: o_pc_write=1, o_pc_src=0, o_jump_or_branch=0, o_bubble=0. Targets follow the formulas below applied to IF/ID = 0. Reset overrides i_enable.
- i_enable=0: IF/ID, regfile and halt hold. Writeback is also gated. o_pc_write=0.
- IF/ID loads i_instruction/i_pc_plus1 on posedge when enabled and not stalled. On flush it loads 0. Flush wins over load; stall wins over flush.
- Outputs are combinational from IF/ID and the regfile: 1-cycle latency from fetch.
- Regfile: written on posedge when i_wb_reg_write && i_wb_addr!=0. Write-through: a read of the same index in the same cycle returns i_wb_data. Register 0 reads 0 always.
- Branch compare (BEQ 000100, BNE 000101): each operand is forwarded from i_mem_alu_result when i_mem_reg_write && !i_mem_mem_read && i_mem_rd==src && src!=0. Otherwise the operand is regfile/bypass.
- Targets: o_addr_branch = pc_plus1 + sext(imm16); o_addr_jump = {pc_plus1[NB_ADDR-1:26], instr[25:0]}, truncated if NB_ADDR≤26; o_addr_register = forwarded rs[NB_ADDR-1:0]. All addition is modulo 2^NB_ADDR (wraps).
- PC select, when no stall: taken branch -> src=2, jb=0. J/JAL -> src=2, jb=1. JR/JALR (opcode 0, funct 001000/001001) -> src=1. Else src=0.
- Any redirect flushes IF/ID on the next posedge: one slot killed.
- Hazards (stall = o_pc_write=0, IF/ID holds, o_bubble=1, o_pc_src forced 0):
  a) load-use: i_ex_mem_read && i_ex_rd!=0 && i_ex_rd ∈ {rs, rt}.
  b) branch/JR operand produced in EX: i_ex_reg_write && i_ex_rd!=0 && i_ex_rd ∈ sources.
  c) branch/JR operand loaded in MEM: i_mem_mem_read && i_mem_rd!=0 && i_mem_rd ∈ sources.
- HALT in IF/ID sets o_halt. After that, o_pc_write=0 until reset.
- Reset mid-stall: the stall clears; IF/ID becomes NOP next cycle.

Decomposition:
- Shared package: opcode/funct constants, PC-src encodings, NB_REG.
- One sub-module, register_file: 2 read ports, 1 write port, debug port, write-through, r0 hardwired to 0.

Test Plan:
- Reset with enable=1 -> regs 0, o_pc_src=0, o_pc_write=1, o_instruction=0.
- WB r1=10 and r2=10 while BEQ r1,r2,+7 is in IF/ID at pc_plus1=5 -> o_pc_src=2, jb=0, o_addr_branch=12, IF/ID=0 next cycle.
- J 0x8 at pc_plus1=7 -> src=2, jb=1, o_addr_jump=8; BNE with equal operands -> src=0.
- EX holds LW r5 and ID holds ADDU r4,r5,r1 -> one cycle of o_pc_write=0, o_bubble=1, IF/ID held; cycle after: o_pc_write=1.
- JR r3, with MEM forwarding ALU result 30 to r3 -> src=1, o_addr_register=30, no stall. Same case with an EX producer -> 1 stall, then redirect.
- i_enable=0 mid-stream -> IF/ID and regs frozen; HALT word -> o_halt=1 sticky, o_pc_write=0 until reset.
